// File: rtl/triangle_raster.sv
`default_nettype none
// ============================================================================
// Module      : triangle_raster
// Description : Captures three vertices over successive cycles, computes the
//               bounding box and orientation, then scans the box in row-major
//               order emitting one registered point per inside candidate.
// Revision    : 1.0 - initial release
// ============================================================================
module triangle_raster #(
  parameter int W         = 3,
  parameter int EDGE_INCL = 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           nt,
  input  logic [W-1:0]   xi,
  input  logic [W-1:0]   yi,
  output logic           busy,
  output logic           po,
  output logic [W-1:0]   xo,
  output logic [W-1:0]   yo,
  output logic           done,
  output logic [2*W:0]   cnt
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    IN1   = 3'd1,
    IN2   = 3'd2,
    SETUP = 3'd3,
    SCAN  = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic [W-1:0] c_xy_one  = {{(W-1){1'b0}}, 1'b1};
  localparam logic [2*W:0] c_cnt_one = {{(2*W){1'b0}}, 1'b1};

  state_t r_state;
  state_t w_next;

  logic [W-1:0] r_x0, r_y0, r_x1, r_y1, r_x2, r_y2;
  logic [W-1:0] r_xmin, r_xmax, r_ymin, r_ymax;
  logic [W-1:0] r_px, r_py;
  logic         r_s_neg;

  logic [W-1:0]           w_xmin, w_xmax, w_ymin, w_ymax;
  logic signed [2*W+2:0]  w_s, w_e0, w_e1, w_e2;
  logic                   w_last, w_inside, w_emit;

  // Zero-extended signed difference; W+1 bits always holds a-b exactly.
  function automatic logic signed [W:0] dif(input logic [W-1:0] a,
                                            input logic [W-1:0] b);
    return $signed({1'b0, a}) - $signed({1'b0, b});
  endfunction

  // ax*by - ay*bx with operands sign-extended so no product can overflow.
  function automatic logic signed [2*W+2:0] cross2(input logic signed [W:0] ax,
                                                   input logic signed [W:0] ay,
                                                   input logic signed [W:0] bx,
                                                   input logic signed [W:0] by);
    logic signed [2*W+1:0] p1;
    logic signed [2*W+1:0] p2;
    p1 = $signed({{(W+1){ax[W]}}, ax}) * $signed({{(W+1){by[W]}}, by});
    p2 = $signed({{(W+1){ay[W]}}, ay}) * $signed({{(W+1){bx[W]}}, bx});
    return $signed({p1[2*W+1], p1}) - $signed({p2[2*W+1], p2});
  endfunction

  function automatic logic [W-1:0] min3(input logic [W-1:0] a,
                                        input logic [W-1:0] b,
                                        input logic [W-1:0] c);
    logic [W-1:0] m;
    m = a;
    if (b < m) m = b;
    if (c < m) m = c;
    return m;
  endfunction

  function automatic logic [W-1:0] max3(input logic [W-1:0] a,
                                        input logic [W-1:0] b,
                                        input logic [W-1:0] c);
    logic [W-1:0] m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

  // Sign test of one edge against the triangle orientation; with a negative
  // orientation the inequality flips, which makes the result winding-agnostic.
  function automatic logic edge_ok(input logic signed [2*W+2:0] e,
                                   input logic neg_orient);
    logic is_neg;
    logic is_zero;
    is_neg  = e[2*W+2];
    is_zero = (e == '0);
    if (neg_orient)
      return (EDGE_INCL != 0) ? (is_neg || is_zero) : is_neg;
    else
      return (EDGE_INCL != 0) ? !is_neg : (!is_neg && !is_zero);
  endfunction

  assign w_xmin = min3(r_x0, r_x1, r_x2);
  assign w_xmax = max3(r_x0, r_x1, r_x2);
  assign w_ymin = min3(r_y0, r_y1, r_y2);
  assign w_ymax = max3(r_y0, r_y1, r_y2);

  assign w_s  = cross2(dif(r_x1, r_x0), dif(r_y1, r_y0),
                       dif(r_x2, r_x0), dif(r_y2, r_y0));
  assign w_e0 = cross2(dif(r_x1, r_x0), dif(r_y1, r_y0),
                       dif(r_px, r_x0), dif(r_py, r_y0));
  assign w_e1 = cross2(dif(r_x2, r_x1), dif(r_y2, r_y1),
                       dif(r_px, r_x1), dif(r_py, r_y1));
  assign w_e2 = cross2(dif(r_x0, r_x2), dif(r_y0, r_y2),
                       dif(r_px, r_x2), dif(r_py, r_y2));

  // Termination uses an explicit last-candidate compare rather than counter
  // wrap, so a box reaching 2^W-1 ends cleanly.
  assign w_last   = (r_px == r_xmax) && (r_py == r_ymax);
  assign w_inside = edge_ok(w_e0, r_s_neg) && edge_ok(w_e1, r_s_neg) &&
                    edge_ok(w_e2, r_s_neg);
  assign w_emit   = (r_state == SCAN) && w_inside;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic plus status outputs decoded from the current state.
  always_comb begin
    w_next = r_state;
    busy   = (r_state != IDLE);
    done   = 1'b0;
    case (r_state)
      IDLE:    if (nt) w_next = IN1;
      IN1:     w_next = IN2;
      IN2:     w_next = SETUP;
      SETUP:   w_next = (w_s == '0) ? DONE : SCAN;
      SCAN:    if (w_last) w_next = DONE;
      DONE: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Vertex capture: V0 on an accepted strobe, V1/V2 on the next two cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_x0 <= '0; r_y0 <= '0;
      r_x1 <= '0; r_y1 <= '0;
      r_x2 <= '0; r_y2 <= '0;
    end else begin
      case (r_state)
        IDLE: if (nt) begin r_x0 <= xi; r_y0 <= yi; end
        IN1:  begin r_x1 <= xi; r_y1 <= yi; end
        IN2:  begin r_x2 <= xi; r_y2 <= yi; end
        default: ;
      endcase
    end
  end

  // Bounding box / orientation latch in SETUP and the row-major scan walker.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_xmin  <= '0; r_xmax <= '0;
      r_ymin  <= '0; r_ymax <= '0;
      r_s_neg <= 1'b0;
      r_px    <= '0; r_py   <= '0;
    end else if (r_state == SETUP) begin
      r_xmin  <= w_xmin; r_xmax <= w_xmax;
      r_ymin  <= w_ymin; r_ymax <= w_ymax;
      r_s_neg <= w_s[2*W+2];
      r_px    <= w_xmin;
      r_py    <= w_ymin;
    end else if ((r_state == SCAN) && !w_last) begin
      if (r_px == r_xmax) begin
        r_px <= r_xmin;
        r_py <= r_py + c_xy_one;
      end else begin
        r_px <= r_px + c_xy_one;
      end
    end
  end

  // Registered point output and running count of emitted points.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      po  <= 1'b0;
      xo  <= '0;
      yo  <= '0;
      cnt <= '0;
    end else begin
      po <= w_emit;
      xo <= w_emit ? r_px : '0;
      yo <= w_emit ? r_py : '0;
      if ((r_state == IDLE) && nt) cnt <= '0;
      else if (w_emit)             cnt <= cnt + c_cnt_one;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_triangle_raster.sv
`default_nettype none
// ============================================================================
// Module      : tb_triangle_raster
// Description : Scoreboard bench driving an edge-inclusive and a strict
//               instance in lockstep with directed triangles.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_triangle_raster;
  localparam int W = 3;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic nt    = 1'b0;
  logic [W-1:0] xi = '0;
  logic [W-1:0] yi = '0;

  logic busy_a, po_a, done_a, busy_b, po_b, done_b;
  logic [W-1:0] xo_a, yo_a, xo_b, yo_b;
  logic [2*W:0] cnt_a, cnt_b;

  logic [2*W-1:0] q_a[$];
  logic [2*W-1:0] q_b[$];

  int n_assert = 0;
  int n_fail   = 0;

  triangle_raster #(.W(W), .EDGE_INCL(1)) u_incl (
    .clk(clk), .reset(reset), .nt(nt), .xi(xi), .yi(yi),
    .busy(busy_a), .po(po_a), .xo(xo_a), .yo(yo_a), .done(done_a), .cnt(cnt_a)
  );

  triangle_raster #(.W(W), .EDGE_INCL(0)) u_strict (
    .clk(clk), .reset(reset), .nt(nt), .xi(xi), .yi(yi),
    .busy(busy_b), .po(po_b), .xo(xo_b), .yo(yo_b), .done(done_b), .cnt(cnt_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int cr(input int ax, input int ay, input int bx, input int by);
    return ax * by - ay * bx;
  endfunction

  // Reference model: push every expected inside point, row-major, per mode.
  task automatic model_push(input int x0, input int y0, input int x1, input int y1,
                            input int x2, input int y2);
    int s, e0, e1, e2;
    int xmin, xmax, ymin, ymax;
    bit in_a, in_b;
    logic [W-1:0] tx, ty;
    s = cr(x1 - x0, y1 - y0, x2 - x0, y2 - y0);
    if (s == 0) return;
    xmin = (x0 < x1) ? x0 : x1; xmin = (x2 < xmin) ? x2 : xmin;
    xmax = (x0 > x1) ? x0 : x1; xmax = (x2 > xmax) ? x2 : xmax;
    ymin = (y0 < y1) ? y0 : y1; ymin = (y2 < ymin) ? y2 : ymin;
    ymax = (y0 > y1) ? y0 : y1; ymax = (y2 > ymax) ? y2 : ymax;
    for (int py = ymin; py <= ymax; py++) begin
      for (int px = xmin; px <= xmax; px++) begin
        e0 = s * cr(x1 - x0, y1 - y0, px - x0, py - y0);
        e1 = s * cr(x2 - x1, y2 - y1, px - x1, py - y1);
        e2 = s * cr(x0 - x2, y0 - y2, px - x2, py - y2);
        in_a = (e0 >= 0) && (e1 >= 0) && (e2 >= 0);
        in_b = (e0 > 0) && (e1 > 0) && (e2 > 0);
        tx = px[W-1:0];
        ty = py[W-1:0];
        if (in_a) q_a.push_back({tx, ty});
        if (in_b) q_b.push_back({tx, ty});
      end
    end
  endtask

  // Output monitor: every po pops the scoreboard; idle outputs must be zero.
  always @(negedge clk) begin
    logic [2*W-1:0] e;
    if (!reset) begin
      if (po_a) begin
        check("po_incl_pending", (q_a.size() > 0), 1);
        if (q_a.size() > 0) begin
          e = q_a.pop_front();
          check("pt_incl", {xo_a, yo_a}, e);
        end
      end else begin
        check("xy_incl_zero", {xo_a, yo_a}, 0);
      end
      if (po_b) begin
        check("po_strict_pending", (q_b.size() > 0), 1);
        if (q_b.size() > 0) begin
          e = q_b.pop_front();
          check("pt_strict", {xo_b, yo_b}, e);
        end
      end else begin
        check("xy_strict_zero", {xo_b, yo_b}, 0);
      end
    end
  end

  task automatic send_vertices(input int x0, input int y0, input int x1, input int y1,
                               input int x2, input int y2);
    @(negedge clk); nt = 1'b1; xi = x0[W-1:0]; yi = y0[W-1:0];
    @(negedge clk); nt = 1'b0; xi = x1[W-1:0]; yi = y1[W-1:0];
    check("busy_after_accept", busy_a, 1);
    check("cnt_cleared", cnt_a, 0);
    @(negedge clk); xi = x2[W-1:0]; yi = y2[W-1:0];
    @(negedge clk); xi = '0; yi = '0;
  endtask

  task automatic run_tri(input int x0, input int y0, input int x1, input int y1,
                         input int x2, input int y2, input int exp_a, input int exp_b,
                         input int exp_scan, input bit mid_nt);
    int cyc;
    model_push(x0, y0, x1, y1, x2, y2);
    send_vertices(x0, y0, x1, y1, x2, y2);
    cyc = 3;
    while (!done_a && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (mid_nt && cyc == 10) begin nt = 1'b1; xi = 3'd7; yi = 3'd7; end
      else nt = 1'b0;
    end
    nt = 1'b0;
    check("done_incl", done_a, 1);
    check("done_strict", done_b, 1);
    check("busy_in_done", busy_a, 1);
    check("scan_cycles", cyc - 4, exp_scan);
    check("cnt_incl", cnt_a, exp_a);
    check("cnt_strict", cnt_b, exp_b);
    @(negedge clk);
    check("busy_low_after", busy_a, 0);
    check("done_low_after", done_a, 0);
    check("cnt_incl_hold", cnt_a, exp_a);
    check("cnt_strict_hold", cnt_b, exp_b);
    check("queue_incl_empty", q_a.size(), 0);
    check("queue_strict_empty", q_b.size(), 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_busy", busy_a, 0);
    check("rst_po", po_a, 0);
    check("rst_xy", {xo_a, yo_a}, 0);
    check("rst_done", done_a, 0);
    check("rst_cnt", cnt_a, 0);
    check("rst_cnt_strict", cnt_b, 0);
    reset = 1'b0;

    run_tri(1, 1, 5, 1, 1, 5, 15, 3, 25, 1'b0);
    run_tri(1, 1, 1, 5, 5, 1, 15, 3, 25, 1'b0);
    run_tri(0, 0, 7, 0, 0, 7, 36, 15, 64, 1'b0);
    run_tri(0, 0, 3, 3, 7, 7, 0, 0, 0, 1'b0);
    run_tri(1, 1, 5, 1, 1, 5, 15, 3, 25, 1'b1);

    // Abort mid-scan with an asynchronous reset.
    model_push(1, 1, 5, 1, 1, 5);
    send_vertices(1, 1, 5, 1, 1, 5);
    repeat (10) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("abort_busy", busy_a, 0);
    check("abort_po", {po_a, po_b}, 0);
    check("abort_xy", {xo_a, yo_a, xo_b, yo_b}, 0);
    check("abort_done", {done_a, done_b}, 0);
    check("abort_cnt", {cnt_a, cnt_b}, 0);
    q_a.delete();
    q_b.delete();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("post_abort_done", {done_a, done_b}, 0);
      check("post_abort_busy", busy_a, 0);
    end
    run_tri(1, 1, 5, 1, 1, 5, 15, 3, 25, 1'b0);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
